// File: rtl/pattern_sequencer.sv
// rtl/pattern_sequencer.sv - job queue and launch scheduler for the pattern_ad9748 generator
module pattern_sequencer #(
    parameter int PAT_WIDTH    = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [PAT_WIDTH-1:0]          cmd_pat,
    input  logic [7:0]                    cmd_duty,
    input  logic [15:0]                   cmd_gap,
    input  logic [7:0]                    cmd_pulses,
    input  logic                          stop_req,
    input  logic                          flush,
    output logic                          gen_pwm_en,
    output logic [PAT_WIDTH-1:0]          gen_pat,
    output logic [7:0]                    gen_duty,
    output logic [15:0]                   gen_gap,
    output logic [7:0]                    gen_pulses,
    input  logic                          gen_busy,
    input  logic                          gen_valid,
    output logic                          seq_busy,
    output logic [$clog2(FIFO_DEPTH):0]   q_level,
    output logic                          job_done,
    output logic [15:0]                   jobs_done,
    output logic                          err_timeout
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int TW = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        RUN,
        DRAIN
    } state_t;

    state_t state;
    state_t state_nx;

    logic [PAT_WIDTH-1:0] q_pat    [FIFO_DEPTH];
    logic [7:0]           q_duty   [FIFO_DEPTH];
    logic [15:0]          q_gap    [FIFO_DEPTH];
    logic [7:0]           q_pulses [FIFO_DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [TW-1:0] timer;
    logic          full;
    logic          push;
    logic          pop;
    logic          infinite;
    logic          stop_pend;
    logic          pwm_nx;
    logic          timed_out;
    logic          done;
    logic          queue_clear;

    assign full        = (q_level == LW'(FIFO_DEPTH));
    assign cmd_ready   = !full && !flush;
    assign push        = cmd_valid && cmd_ready;
    assign pop         = (state == IDLE) && (q_level != '0);
    assign infinite    = (gen_pulses == 8'd0);
    assign seq_busy    = (state != IDLE);
    // A stop that was pending when the job completes discards everything still queued.
    assign queue_clear = flush || (done && stop_pend);

    always_comb begin
        state_nx  = state;
        pwm_nx    = 1'b0;
        timed_out = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (q_level != '0) state_nx = LAUNCH;
            end
            LAUNCH: begin
                pwm_nx   = 1'b1;
                state_nx = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                pwm_nx = infinite;
                if (gen_busy) begin
                    state_nx = RUN;
                end else if (timer == TW'(BUSY_TIMEOUT - 1)) begin
                    timed_out = 1'b1;
                    pwm_nx    = 1'b0;
                    state_nx  = IDLE;
                end
            end
            RUN: begin
                // Finite jobs already dropped enable; infinite jobs hold it until a stop arrives.
                pwm_nx = infinite && !stop_pend;
                if (gen_valid) state_nx = DRAIN;
            end
            DRAIN: begin
                if (!gen_busy && !gen_valid) begin
                    done     = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_pat[wr_ptr]    <= cmd_pat;
            q_duty[wr_ptr]   <= cmd_duty;
            q_gap[wr_ptr]    <= cmd_gap;
            q_pulses[wr_ptr] <= cmd_pulses;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            gen_pwm_en  <= 1'b0;
            gen_pat     <= '0;
            gen_duty    <= '0;
            gen_gap     <= '0;
            gen_pulses  <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            q_level     <= '0;
            timer       <= '0;
            stop_pend   <= 1'b0;
            job_done    <= 1'b0;
            jobs_done   <= '0;
            err_timeout <= 1'b0;
        end else begin
            state      <= state_nx;
            gen_pwm_en <= pwm_nx;
            job_done   <= done;

            if (pop) begin
                gen_pat    <= q_pat[rd_ptr];
                gen_duty   <= q_duty[rd_ptr];
                gen_gap    <= q_gap[rd_ptr];
                gen_pulses <= q_pulses[rd_ptr];
            end

            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (queue_clear) begin
                rd_ptr  <= wr_ptr;
                q_level <= LW'(push);
            end else begin
                if (pop) rd_ptr <= rd_ptr + AW'(1);
                q_level <= q_level + LW'(push) - LW'(pop);
            end

            timer <= (state == WAIT_BUSY) ? timer + TW'(1) : '0;

            if (done || timed_out) begin
                stop_pend <= 1'b0;
            end else if (stop_req && state != IDLE) begin
                stop_pend <= 1'b1;
            end

            if (timed_out) err_timeout <= 1'b1;
            if (done) jobs_done <= jobs_done + 16'd1;
        end
    end

endmodule
